// File: rtl/rlbp_code_fifo_if.sv
// Wishbone slave bundle for the RLBP code FIFO register window.
interface rlbp_code_fifo_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/rlbp_code_fifo.sv
// Assembles synchronized comparator decisions into RLBP codes, buffers them in a FIFO
// and serves them over Wishbone. Define RLBP_FIFO_IRQ_EN to enable the threshold interrupt.
module rlbp_code_fifo #(
    parameter int          BITS_PER_CODE = 8,
    parameter int          DEPTH         = 16,
    parameter logic [7:0]  BASE_OFFSET   = 8'h80
) (
    input  logic             wb_clk_i,
    input  logic             rst,
    rlbp_code_fifo_if.slave  wb,
    input  logic             cmp_bit,
    input  logic             cmp_valid,
    input  logic             frame_clr,
    output logic             irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BITS_PER_CODE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS_PER_CODE - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [2:0] v_sync, f_sync;
    logic [1:0] b_sync;
    logic       v_edge, f_edge, bit_s;

    logic                     en_q, ovf_q, partial_q, ack_q;
    logic [31:0]              dat_q, rdata;
    logic [BITS_PER_CODE-1:0] code_q, code_n, push_data;
    logic [CW-1:0]            cnt_q, cnt_n;
    logic                     push_n, push_req, partial_set;
    logic [BITS_PER_CODE-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [LW-1:0]            level_q;
    logic                     empty, full, do_push, do_pop, overflow;
    logic                     wb_req, access, wr_en, ctrl_wr, flush, clrf, pop_req;
    logic [3:0]               offs;
    logic                     unused_bits;

    // The third stage of each valid/frame chain holds the previous synced level for edge detection.
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            v_sync <= '0;
            f_sync <= '0;
            b_sync <= '0;
        end else begin
            v_sync <= {v_sync[1:0], cmp_valid};
            f_sync <= {f_sync[1:0], frame_clr};
            b_sync <= {b_sync[0], cmp_bit};
        end
    end

    assign v_edge = v_sync[1] & ~v_sync[2];
    assign f_edge = f_sync[1] & ~f_sync[2];
    assign bit_s  = b_sync[1];

    assign wb_req  = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:28] == 4'h3)
                   & (wb.wbs_adr_i[7:4] == BASE_OFFSET[7:4]);
    assign access  = wb_req & ~ack_q;
    assign offs    = wb.wbs_adr_i[3:0];
    assign wr_en   = access & wb.wbs_we_i & wb.wbs_sel_i[0];
    assign ctrl_wr = wr_en & (offs == 4'h8);
    assign flush   = ctrl_wr & wb.wbs_dat_i[1];
    assign clrf    = ctrl_wr & wb.wbs_dat_i[2];
    assign pop_req = access & ~wb.wbs_we_i & (offs == 4'h0);
    assign unused_bits = ^{wb.wbs_adr_i[27:8], wb.wbs_dat_i[31:3], wb.wbs_sel_i[3:1]};

    // A frame edge in the same cycle as a valid edge acts on the post-shift count.
    always_comb begin
        code_n      = code_q;
        cnt_n       = cnt_q;
        push_n      = 1'b0;
        partial_set = 1'b0;
        if (!en_q) begin
            cnt_n = '0;
        end else begin
            if (v_edge) begin
                code_n = {code_q[BITS_PER_CODE-2:0], bit_s};
                if (cnt_q == CNT_LAST) begin
                    cnt_n  = '0;
                    push_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            if (f_edge) begin
                partial_set = (cnt_n != '0);
                cnt_n       = '0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst || flush) begin
            code_q    <= '0;
            cnt_q     <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
        end else begin
            code_q   <= code_n;
            cnt_q    <= cnt_n;
            push_req <= push_n;
            if (push_n) push_data <= code_n;
        end
    end

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_FULL);
    assign do_pop   = pop_req & ~empty;
    assign do_push  = push_req & (~full | do_pop);
    assign overflow = push_req & full & ~do_pop & ~flush;

    always_ff @(posedge wb_clk_i) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

`ifdef RLBP_FIFO_IRQ_EN
    logic [7:0] thresh_q;

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            thresh_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_en && offs == 4'hC) thresh_q <= wb.wbs_dat_i[7:0];
            irq_o <= ((thresh_q != 8'h0) && (8'(level_q) >= thresh_q)) || ovf_q;
        end
    end
`else
    logic [7:0] thresh_q;
    assign thresh_q = 8'h0;
    assign irq_o    = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (offs)
            4'h0: if (!empty) begin
                rdata[BITS_PER_CODE-1:0] = mem[rd_ptr];
                rdata[31]                = 1'b1;
            end
            4'h4: rdata = {8'h0, 8'(cnt_q), 8'(level_q), 4'h0, partial_q, ovf_q, full, empty};
            4'h8: rdata = {31'h0, en_q};
            4'hC: rdata = {24'h0, thresh_q};
            default: rdata = '0;
        endcase
    end

    // Sticky flags: a same-cycle set wins over CLRF so no event is lost.
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            ack_q <= access;
            dat_q <= access ? rdata : 32'h0;
            if (ctrl_wr) en_q <= wb.wbs_dat_i[0];
            if (clrf) begin
                ovf_q     <= 1'b0;
                partial_q <= 1'b0;
            end
            if (overflow) ovf_q <= 1'b1;
            if (partial_set && !flush) partial_q <= 1'b1;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_rlbp_code_fifo.sv
// Directed bench for rlbp_code_fifo: bus reads are scoreboarded against hand-computed values.
module tb_rlbp_code_fifo;
  logic wb_clk_i = 1'b0;
  logic rst = 1'b1;
  logic cmp_bit = 1'b0;
  logic cmp_valid = 1'b0;
  logic frame_clr = 1'b0;
  logic irq_o;
  logic irq_seen = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];
  string name_q[$];

  rlbp_code_fifo_if wb();

  rlbp_code_fifo dut (
    .wb_clk_i (wb_clk_i),
    .rst      (rst),
    .wb       (wb.slave),
    .cmp_bit  (cmp_bit),
    .cmp_valid(cmp_valid),
    .frame_clr(frame_clr),
    .irq_o    (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Read-data monitor: pops the scoreboard whenever a read is acknowledged.
  always @(negedge wb_clk_i) begin
    if (irq_o) irq_seen = 1'b1;
    if (wb.wbs_ack_o && !wb.wbs_we_i) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_ack: got ack with data %08h expected no ack", wb.wbs_dat_o);
      end else begin
        check(name_q.pop_front(), wb.wbs_dat_o, exp_q.pop_front());
      end
    end
  end

  task automatic bus_idle();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, input string name);
    logic got = 1'b0;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = 32'h3000_0000 | {24'h0, 8'h80 + off};
    wb.wbs_dat_i = dat;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb.wbs_ack_o) got = 1'b1;
    end
    @(negedge wb_clk_i); #1;
    bus_idle();
    if (!got) begin
      total_cnt++;
      $display("FAIL %s_ack_timeout: got no ack expected ack", name);
      if (!we) begin
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
      end
    end
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    wb_xfer(1'b0, off, 32'h0, 4'hF, name);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] dat);
    wb_xfer(1'b1, off, dat, 4'hF, "write");
  endtask

  task automatic send_bit(input logic b);
    cmp_bit = b;
    cmp_valid = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 cmp_valid = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_code(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic frame_pulse();
    frame_clr = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 frame_clr = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    bus_idle();
    repeat (3) @(posedge wb_clk_i);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
    check("rst_dat", wb.wbs_dat_o, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    wb_read(8'h04, 32'h0000_0001, "rst_status");
    wb_read(8'h08, 32'h0, "rst_ctrl");
    wb_read(8'h0C, 32'h0, "rst_thresh");

    // Write with sel[0]=0 is ignored
    wb_xfer(1'b1, 8'h08, 32'h1, 4'hE, "sel_write");
    wb_read(8'h08, 32'h0, "sel0_ignored");

    // Basic code assembly
    wb_write(8'h08, 32'h1);
    wb_read(8'h08, 32'h1, "ctrl_en");
    send_code(8'hB2);
    wb_read(8'h04, 32'h0000_0100, "one_code_status");
    wb_read(8'h00, 32'h8000_00B2, "first_data");
    wb_read(8'h04, 32'h0000_0001, "after_pop_status");
    wb_read(8'h00, 32'h0, "empty_data");

    // Overflow: 17 codes into 16 entries, oldest retained
    for (int i = 0; i < 17; i++) send_code(8'(8'hA0 + i));
    wb_read(8'h04, 32'h0000_1006, "full_ovf_status");
    wb_read(8'h00, 32'h8000_00A0, "oldest_code");
    wb_write(8'h08, 32'h5);
    wb_read(8'h04, 32'h0000_0F00, "clrf_status");
    for (int i = 1; i < 16; i++) wb_read(8'h00, 32'h8000_0000 | 32'(8'hA0 + i), "drain_data");
    wb_read(8'h04, 32'h0000_0001, "drained_status");

    // Partial frame
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (4) @(posedge wb_clk_i);
    #1;
    wb_read(8'h04, 32'h0005_0001, "five_bits_status");
    frame_pulse();
    wb_read(8'h04, 32'h0000_0009, "partial_status");
    send_code(8'h5A);
    wb_read(8'h00, 32'h8000_005A, "aligned_after_partial");
    wb_write(8'h08, 32'h5);

    // Eighth bit coincides with a frame edge
    for (int i = 7; i >= 1; i--) send_bit(8'h3C >> i);
    cmp_bit = 1'b0;
    cmp_valid = 1'b1;
    frame_clr = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 cmp_valid = 1'b0;
    frame_clr = 1'b0;
    repeat (6) @(posedge wb_clk_i);
    #1;
    wb_read(8'h04, 32'h0000_0100, "coincident_status");
    wb_read(8'h00, 32'h8000_003C, "coincident_data");

    // FLUSH lands on the cycle the completed code would be written
    for (int i = 7; i >= 1; i--) send_bit(8'h77 >> i);
    cmp_bit = 1'b1;
    cmp_valid = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_write(8'h08, 32'h3);
    cmp_valid = 1'b0;
    repeat (6) @(posedge wb_clk_i);
    #1;
    wb_read(8'h04, 32'h0000_0001, "flush_status");
    wb_read(8'h08, 32'h1, "flush_keeps_en");
    wb_read(8'h00, 32'h0, "flush_data_empty");

    // Threshold interrupt
    wb_write(8'h0C, 32'h3);
`ifdef RLBP_FIFO_IRQ_EN
    wb_read(8'h0C, 32'h3, "thresh_rw");
    send_code(8'h11);
    send_code(8'h22);
    check("irq_below_thresh", {31'h0, irq_o}, 32'h0);
    send_code(8'h33);
    check("irq_at_thresh", {31'h0, irq_o}, 32'h1);
    wb_read(8'h00, 32'h8000_0011, "irq_pop");
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("irq_after_pop", {31'h0, irq_o}, 32'h0);
    wb_write(8'h0C, 32'h0);
`else
    wb_read(8'h0C, 32'h0, "thresh_disabled");
    send_code(8'h11);
    send_code(8'h22);
    send_code(8'h33);
    check("irq_tied_low", {31'h0, irq_o}, 32'h0);
    wb_read(8'h00, 32'h8000_0011, "irq_pop");
`endif
    wb_read(8'h00, 32'h8000_0022, "irq_drain1");
    wb_read(8'h00, 32'h8000_0033, "irq_drain2");

    // Unmapped offset in the window
    wb_read(8'h01, 32'h0, "unmapped_read");
    wb_read(8'h04, 32'h0000_0001, "unmapped_no_effect");

    // Request outside the window must not be acknowledged
    begin
      logic acked = 1'b0;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_adr_i = 32'h3000_0010;
      repeat (5) begin
        @(posedge wb_clk_i); #1;
        if (wb.wbs_ack_o) acked = 1'b1;
      end
      bus_idle();
      check("no_ack_outside", {31'h0, acked}, 32'h0);
    end

    // Reset during a pending request
    send_bit(1'b1);
    send_bit(1'b0);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_adr_i = 32'h3000_0084;
    rst = 1'b1;
    @(posedge wb_clk_i); #1;
    check("rst_mid_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
    bus_idle();
    rst = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst_mid_ack2", {31'h0, wb.wbs_ack_o}, 32'h0);
    wb_read(8'h08, 32'h0, "rst_mid_ctrl");
    wb_read(8'h04, 32'h0000_0001, "rst_mid_status");

    repeat (4) @(posedge wb_clk_i);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
`ifndef RLBP_FIFO_IRQ_EN
    check("irq_never_high", {31'h0, irq_seen}, 32'h0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
